// File: rtl/sqrt_arbiter_if.sv
// Handshake bundle between two square-root requesters, the arbiter and the
// shared square-root iteration unit.
interface sqrt_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [22:0] req0_data, req1_data;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [22:0] rsp0_data, rsp1_data;
    logic        it_enable;
    logic        it_n_valid;
    logic [22:0] it_op;
    logic        it_result;
    logic [21:0] it_res;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        input  rsp0_ready, rsp1_ready,
        output it_enable, it_n_valid, it_op,
        input  it_result, it_res,
        output busy
    );

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        output rsp0_ready, rsp1_ready,
        input  it_enable, it_n_valid, it_op,
        output it_result, it_res,
        input  busy
    );
endinterface

// File: rtl/sqrt_arbiter.sv
// Two-requester arbiter in front of one square-root iteration unit; a unit that
// never finishes is cut off after TIMEOUT and answered with an error NaN.
module sqrt_arbiter #(
    parameter int TIMEOUT = 15  // legal 13..15, held in a 4-bit counter
) (
    input  logic          clk,
    input  logic          rst,
    sqrt_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    localparam logic [3:0]  TIMEOUT_CNT = 4'(TIMEOUT);
    localparam logic [22:0] ERR_RSP     = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'sd16, 11'h400};

    state_t      state, state_nxt;
    logic        ptr, owner, grant, any_valid, done;
    logic [3:0]  cnt;
    logic [22:0] op, rsp0, rsp1, cap;

    // A real result beats a coincident timeout.
    function automatic logic [22:0] capture_word(input logic hit, input logic [21:0] res);
        return hit ? {1'b0, res} : ERR_RSP;
    endfunction

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant     = (bus.req0_valid & bus.req1_valid) ? ptr : bus.req1_valid;
        done      = bus.it_result | (cnt == TIMEOUT_CNT);
        cap       = capture_word(bus.it_result, bus.it_res);
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.it_enable  = 1'b0;
        bus.it_n_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = any_valid & ~grant & ~rst;
                bus.req1_ready = any_valid &  grant & ~rst;
                if (any_valid) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                bus.it_enable  = 1'b1;
                bus.it_n_valid = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT: begin
                bus.it_enable = 1'b1;
                if (done) state_nxt = RESP;
            end
            RESP: begin
                bus.it_enable  = 1'b1;
                bus.rsp0_valid = ~owner;
                bus.rsp1_valid = owner;
                if (owner ? bus.rsp1_ready : bus.rsp0_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus.busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            owner <= 1'b0;
            cnt   <= '0;
            op    <= '0;
            rsp0  <= '0;
            rsp1  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_valid) begin
                op    <= grant ? bus.req1_data : bus.req0_data;
                owner <= grant;
                ptr   <= ~grant;
            end
            if (state == LAUNCH)    cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 4'd1;
            if (state == WAIT && done) begin
                if (owner) rsp1 <= cap;
                else       rsp0 <= cap;
            end
        end
    end

    assign bus.it_op     = op;
    assign bus.rsp0_data = rsp0;
    assign bus.rsp1_data = rsp1;
endmodule
